// File: rtl/ccm_pkg.sv
// Shared types and constants for the colour-correction coefficient controller.
package ccm_pkg;

    localparam int DEF_FRAC_BITS = 6;
    localparam int DEF_INT_BITS  = 6;
    localparam int COEFF_W       = DEF_INT_BITS + DEF_FRAC_BITS;
    localparam int NUM_COEFF     = 9;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    localparam coeff_t ONE  = coeff_t'(1 << DEF_FRAC_BITS);
    localparam coeff_t ZERO = '0;

    // Element 0 is the rightmost in the concatenation (row*3+col indexing).
    localparam logic [NUM_COEFF-1:0][COEFF_W-1:0] IDENTITY =
        {ONE, ZERO, ZERO, ZERO, ONE, ZERO, ZERO, ZERO, ONE};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIRTY = 2'd1,
        ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/ccm_coeff_ctrl_if.sv
// Host-side coefficient write/commit bus.
interface ccm_cfg_if #(
    parameter int COEFF_W = ccm_pkg::COEFF_W
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [3:0]         cfg_addr;
    logic [COEFF_W-1:0] cfg_data;
    logic               cfg_commit;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        output cfg_commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_commit,
        output cfg_ready
    );
endinterface

// File: rtl/ccm_coeff_bank.sv
// Nine-entry coefficient register bank: one write port, full parallel load,
// asynchronous reset to the identity matrix.
module ccm_coeff_bank
    import ccm_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int CW        = COEFF_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [3:0]                    waddr,
    input  logic [CW-1:0]                 wdata,
    input  logic                          load,
    input  logic [NUM_COEFF-1:0][CW-1:0]  load_data,
    output logic [NUM_COEFF-1:0][CW-1:0]  q
);

    logic [CW-1:0] entry_reg [NUM_COEFF];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEFF; gi++) begin : g_entry
            // Diagonal entries (0, 4, 8) reset to 1.0 in fixed point.
            localparam logic [CW-1:0] INIT = (gi % 4 == 0) ? CW'(1 << FRAC_BITS) : '0;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg[gi] <= INIT;
                end else if (load) begin
                    entry_reg[gi] <= load_data[gi];
                end else if (we && (waddr == 4'(gi))) begin
                    entry_reg[gi] <= wdata;
                end
            end

            assign q[gi] = entry_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/ccm_coeff_ctrl.sv
// Shadow/active coefficient controller with frame-aligned atomic commit.
// Optional readback port enabled by defining CCM_READBACK_EN.
module ccm_coeff_ctrl
    import ccm_pkg::*;
#(
    parameter int  FRAC_BITS = DEF_FRAC_BITS,
    parameter int  INT_BITS  = DEF_INT_BITS,
    localparam int CW        = INT_BITS + FRAC_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    ccm_cfg_if.slave                            cfg,
    input  logic                                frame_start,
    output logic signed [NUM_COEFF-1:0][CW-1:0] cc_coeff,
    output logic                                pending,
    output logic                                dirty,
    output logic                                cfg_err,
    output logic [7:0]                          swap_count
`ifdef CCM_READBACK_EN
    ,
    input  logic [3:0]                          rd_addr,
    input  logic                                rd_bank,
    output logic [CW-1:0]                       rd_data
`endif
);

    state_t     state_reg;
    logic       cfg_ready_reg;
    logic       pending_reg;
    logic       dirty_reg;
    logic       cfg_err_reg;
    logic [7:0] swap_count_reg;

    logic [NUM_COEFF-1:0][CW-1:0] shadow_q;
    logic [NUM_COEFF-1:0][CW-1:0] active_q;

    logic accept;
    logic addr_ok;
    logic swap;

    assign accept  = cfg.cfg_valid & cfg_ready_reg;
    assign addr_ok = cfg.cfg_addr < 4'(NUM_COEFF);
    assign swap    = (state_reg == ARMED) & frame_start;

    // cfg_ready is low only while armed, so the shadow never changes under a pending swap.
    ccm_coeff_bank #(.FRAC_BITS(FRAC_BITS), .CW(CW)) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .we        (accept & addr_ok),
        .waddr     (cfg.cfg_addr),
        .wdata     (cfg.cfg_data),
        .load      (1'b0),
        .load_data ('0),
        .q         (shadow_q)
    );

    ccm_coeff_bank #(.FRAC_BITS(FRAC_BITS), .CW(CW)) u_active (
        .clk       (clk),
        .reset     (reset),
        .we        (1'b0),
        .waddr     (4'd0),
        .wdata     ('0),
        .load      (swap),
        .load_data (shadow_q),
        .q         (active_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cfg_ready_reg  <= 1'b1;
            pending_reg    <= 1'b0;
            dirty_reg      <= 1'b0;
            cfg_err_reg    <= 1'b0;
            swap_count_reg <= 8'd0;
        end else begin
            if (accept && !addr_ok) begin
                cfg_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE, DIRTY: begin
                    // A same-cycle write lands in the shadow before the commit freezes it.
                    if (cfg.cfg_commit) begin
                        state_reg     <= ARMED;
                        cfg_ready_reg <= 1'b0;
                        pending_reg   <= 1'b1;
                        dirty_reg     <= 1'b1;
                    end else if (accept && addr_ok) begin
                        state_reg <= DIRTY;
                        dirty_reg <= 1'b1;
                    end
                end
                ARMED: begin
                    if (frame_start) begin
                        state_reg      <= IDLE;
                        cfg_ready_reg  <= 1'b1;
                        pending_reg    <= 1'b0;
                        dirty_reg      <= 1'b0;
                        swap_count_reg <= swap_count_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b1;
                    pending_reg   <= 1'b0;
                    dirty_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = cfg_ready_reg;
    assign cc_coeff      = active_q;
    assign pending       = pending_reg;
    assign dirty         = dirty_reg;
    assign cfg_err       = cfg_err_reg;
    assign swap_count    = swap_count_reg;

`ifdef CCM_READBACK_EN
    logic [CW-1:0] rd_data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_addr < 4'(NUM_COEFF)) begin
            rd_data_reg <= rd_bank ? shadow_q[rd_addr] : active_q[rd_addr];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign rd_data = rd_data_reg;
`endif

endmodule

// File: tb/tb_ccm_coeff_ctrl.sv
// Scoreboard bench for ccm_coeff_ctrl: a reference model pushes the expected
// outputs at each driven edge, a monitor pops and compares shortly after.
module tb_ccm_coeff_ctrl;

    localparam int W = 12;

    typedef struct packed {
        logic [9*W-1:0] coeff;
        logic           pend;
        logic           drty;
        logic           rdy;
        logic           err;
        logic [7:0]     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic signed [8:0][W-1:0] cc_coeff;
    logic       pending;
    logic       dirty;
    logic       cfg_err;
    logic [7:0] swap_count;

    always #5 clk = ~clk;

    ccm_cfg_if cfg_bus ();

`ifdef CCM_READBACK_EN
    logic [3:0]   rd_addr = 4'd0;
    logic         rd_bank = 1'b0;
    logic [W-1:0] rd_data;
`endif

    ccm_coeff_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_bus.slave),
        .frame_start (frame_start),
        .cc_coeff    (cc_coeff),
        .pending     (pending),
        .dirty       (dirty),
        .cfg_err     (cfg_err),
        .swap_count  (swap_count)
`ifdef CCM_READBACK_EN
        ,
        .rd_addr     (rd_addr),
        .rd_bank     (rd_bank),
        .rd_data     (rd_data)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [W-1:0] m_sh [9];
    logic [W-1:0] m_act [9];
    int           m_state;
    logic         m_err;
    logic [7:0]   m_cnt;
    exp_t         sb_q [$];

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) begin
            m_sh[i]  = (i == 0 || i == 4 || i == 8) ? 12'd64 : 12'd0;
            m_act[i] = m_sh[i];
        end
        m_state = 0;
        m_err   = 1'b0;
        m_cnt   = 8'd0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < 9; i++) e.coeff[i*W +: W] = m_act[i];
        e.pend = (m_state == 2);
        e.drty = (m_state != 0);
        e.rdy  = (m_state != 2);
        e.err  = m_err;
        e.cnt  = m_cnt;
        return e;
    endfunction

    function automatic void dump_expected(input exp_t e);
        $display("  expect pend=%0d dirty=%0d ready=%0d err=%0d count=%0d", e.pend, e.drty, e.rdy, e.err, e.cnt);
    endfunction

    task automatic step(input bit valid, input logic [3:0] addr, input logic [W-1:0] data,
                        input bit commit, input bit fs);
        bit acc;
        cfg_bus.cfg_valid  = valid;
        cfg_bus.cfg_addr   = addr;
        cfg_bus.cfg_data   = data;
        cfg_bus.cfg_commit = commit;
        frame_start        = fs;
        @(posedge clk);
        acc = valid && (m_state != 2);
        if (acc && addr > 4'd8) m_err = 1'b1;
        if (m_state == 2) begin
            if (fs) begin
                for (int i = 0; i < 9; i++) m_act[i] = m_sh[i];
                m_state = 0;
                m_cnt   = m_cnt + 8'd1;
                if (m_cnt < 2 || m_cnt > 254) $display("swap n=%0d", m_cnt);
            end
        end else begin
            if (acc && addr <= 4'd8) begin
                m_sh[addr] = data;
                $display("write idx=%0d data=%03h", addr, data);
            end else if (acc) begin
                $display("write idx=%0d discarded", addr);
            end
            if (commit) m_state = 2;
            else if (acc && addr <= 4'd8) m_state = 1;
        end
        sb_q.push_back(model_out());
        @(negedge clk);
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_commit = 1'b0;
        frame_start        = 1'b0;
    endtask

    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("coeff", {20'b0, cc_coeff}, {20'b0, e.coeff});
            check("pending", {127'b0, pending}, {127'b0, e.pend});
            check("dirty", {127'b0, dirty}, {127'b0, e.drty});
            check("ready", {127'b0, cfg_bus.cfg_ready}, {127'b0, e.rdy});
            check("cfg_err", {127'b0, cfg_err}, {127'b0, e.err});
            check("swap_count", {120'b0, swap_count}, {120'b0, e.cnt});
        end
    end

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 9; i++)
            check({tag, "_coeff"}, {116'b0, cc_coeff[i]},
                  (i == 0 || i == 4 || i == 8) ? 128'd64 : 128'd0);
        check({tag, "_pending"}, {127'b0, pending}, 128'd0);
        check({tag, "_dirty"}, {127'b0, dirty}, 128'd0);
        check({tag, "_ready"}, {127'b0, cfg_bus.cfg_ready}, 128'd1);
    endtask

    initial begin
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_addr   = 4'd0;
        cfg_bus.cfg_data   = '0;
        cfg_bus.cfg_commit = 1'b0;
        frame_start        = 1'b0;
        reset              = 1'b1;
        model_reset();
        #12;
        check_reset_state("reset");
        check("reset_err", {127'b0, cfg_err}, 128'd0);
        check("reset_count", {120'b0, swap_count}, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write / commit / swap
        step(1, 4'd1, 12'hFE0, 0, 0);
        check("active_before_swap", {116'b0, cc_coeff[1]}, 128'd0);
        step(0, 4'd0, 12'h000, 1, 0);
        step(0, 4'd0, 12'h000, 0, 1);
        check("coeff1_after_swap", {116'b0, cc_coeff[1]}, 128'hFE0);

        // Writes stall while armed
        step(0, 4'd0, 12'h000, 1, 0);
        step(1, 4'd2, 12'd5, 0, 0);
        step(1, 4'd2, 12'd5, 0, 0);
        step(1, 4'd2, 12'd5, 0, 1);
        step(1, 4'd2, 12'd5, 0, 0);
        check("shadow_only_write", {116'b0, cc_coeff[2]}, 128'd0);

        // Out-of-range address: accepted, discarded, sticky error
        step(1, 4'd9, 12'h123, 0, 0);
        step(1, 4'd15, 12'h456, 0, 0);
        step(0, 4'd0, 12'h000, 0, 1);

        // Commit + frame_start together only arms
        step(0, 4'd0, 12'h000, 1, 1);
        step(0, 4'd0, 12'h000, 0, 1);

        // Same-cycle write + commit
        step(1, 4'd4, 12'd128, 1, 0);
        step(0, 4'd0, 12'h000, 1, 0);
        step(0, 4'd0, 12'h000, 0, 1);
        check("coeff4_write_commit", {116'b0, cc_coeff[4]}, 128'd128);

        // Reset during ARMED aborts the swap immediately
        step(1, 4'd7, 12'h7FF, 1, 0);
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        check("midreset_err", {127'b0, cfg_err}, 128'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random writes across a commit
        for (int k = 0; k < 12; k++)
            step(1, 4'($urandom_range(0, 10)), 12'($urandom), 0, 0);
        step(0, 4'd0, 12'h000, 1, 0);
        step(0, 4'd0, 12'h000, 0, 1);

        // swap_count wrap: 255 more swaps from 1 lands on 0
        for (int k = 0; k < 255; k++) begin
            step(0, 4'd0, 12'h000, 1, 0);
            step(0, 4'd0, 12'h000, 0, 1);
        end
        check("swap_count_wrap", {120'b0, swap_count}, 128'd0);

        @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        if (errors != 0) dump_expected(model_out());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
